// File: rtl/ctrl_rx_multi.sv
// ctrl_rx_multi: multi-channel UART receiver for player controllers.
//
// Each channel receives 8N1 frames (LSB first) on its own asynchronous line.
// A frame with a good stop bit and bit 7 clear carries a 7-bit button state
// that is held on o_btn; newly pressed buttons pulse on o_press. Any other
// frame pulses o_frm_err. A channel that accepts no frame for TIMEOUT_CYC
// cycles drops its link and releases all of its buttons.
//
// Ports:
//   i_clk      single clock, rising edge
//   i_rst      synchronous active-high reset
//   i_rx       [NUM_CH]   asynchronous UART lines, idle high
//   o_btn      [NUM_CH*7] held buttons, channel c at [7c+6:7c]
//                         (right, left, jump, squat, attack, defend, select)
//   o_press    [NUM_CH*7] one-cycle pulse per newly pressed button
//   o_valid    [NUM_CH]   one-cycle pulse per accepted frame
//   o_frm_err  [NUM_CH]   one-cycle pulse per rejected frame
//   o_link     [NUM_CH]   high while an accepted frame arrived within TIMEOUT_CYC
module ctrl_rx_multi #(
    parameter int NUM_CH       = 2,
    parameter int CLKS_PER_BIT = 938,
    parameter int TIMEOUT_CYC  = 10_800_000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NUM_CH-1:0]     i_rx,
    output logic [NUM_CH*7-1:0]   o_btn,
    output logic [NUM_CH*7-1:0]   o_press,
    output logic [NUM_CH-1:0]     o_valid,
    output logic [NUM_CH-1:0]     o_frm_err,
    output logic [NUM_CH-1:0]     o_link
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [BAUD_W-1:0] HALF_M1 = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_M1 = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [TO_W-1:0]   TO_MAX  = TO_W'(TIMEOUT_CYC);
    localparam logic [TO_W-1:0]   TO_PRE  = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } state_t;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic              sync1_q;
        logic              sync2_q;
        state_t            state_q;
        logic [BAUD_W-1:0] baud_q;
        logic [2:0]        bit_q;
        logic [7:0]        shift_q;
        logic [6:0]        btn_q;
        logic [6:0]        press_q;
        logic              valid_q;
        logic              err_q;
        logic              link_q;
        logic [TO_W-1:0]   tmo_q;
        logic              accept_d;

        // The stop sample is the decision point: a good stop bit with a
        // clear bit 7 is the only path that updates the button state.
        assign accept_d = (state_q == STOP) && (baud_q == FULL_M1) &&
                          sync2_q && !shift_q[7];

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
                state_q <= IDLE;
                baud_q  <= '0;
                bit_q   <= '0;
                shift_q <= '0;
                btn_q   <= '0;
                press_q <= '0;
                valid_q <= 1'b0;
                err_q   <= 1'b0;
                link_q  <= 1'b0;
                tmo_q   <= '0;
            end else begin
                sync1_q <= i_rx[c];
                sync2_q <= sync1_q;

                valid_q <= accept_d;
                press_q <= accept_d ? (shift_q[6:0] & ~btn_q) : 7'd0;
                err_q   <= 1'b0;
                baud_q  <= baud_q + BAUD_W'(1);

                case (state_q)
                    IDLE: begin
                        baud_q <= '0;
                        if (!sync2_q) state_q <= START;
                    end
                    START: begin
                        // Mid-start-bit check rejects short low glitches.
                        if (baud_q == HALF_M1) begin
                            baud_q <= '0;
                            bit_q  <= '0;
                            state_q <= sync2_q ? IDLE : DATA;
                        end
                    end
                    DATA: begin
                        if (baud_q == FULL_M1) begin
                            baud_q  <= '0;
                            shift_q <= {sync2_q, shift_q[7:1]};
                            bit_q   <= bit_q + 3'd1;
                            if (bit_q == 3'd7) state_q <= STOP;
                        end
                    end
                    STOP: begin
                        if (baud_q == FULL_M1) begin
                            baud_q <= '0;
                            if (sync2_q) begin
                                state_q <= IDLE;
                                if (shift_q[7]) err_q <= 1'b1;
                            end else begin
                                // Low stop bit (or break): flag once, then
                                // wait for the line to recover.
                                err_q   <= 1'b1;
                                state_q <= WAIT_HI;
                            end
                        end
                    end
                    WAIT_HI: begin
                        baud_q <= '0;
                        if (sync2_q) state_q <= IDLE;
                    end
                    default: begin
                        baud_q  <= '0;
                        state_q <= IDLE;
                    end
                endcase

                // An accepted frame takes priority over a coincident timeout.
                if (accept_d) begin
                    btn_q  <= shift_q[6:0];
                    link_q <= 1'b1;
                    tmo_q  <= '0;
                end else begin
                    if (tmo_q != TO_MAX) tmo_q <= tmo_q + TO_W'(1);
                    if (tmo_q >= TO_PRE) begin
                        link_q <= 1'b0;
                        btn_q  <= '0;
                    end
                end
            end
        end

        assign o_btn[7*c +: 7]   = btn_q;
        assign o_press[7*c +: 7] = press_q;
        assign o_valid[c]        = valid_q;
        assign o_frm_err[c]      = err_q;
        assign o_link[c]         = link_q;
    end

endmodule

// File: tb/tb_ctrl_rx_multi.sv
// Directed bench for ctrl_rx_multi with two channels, 16 clocks per bit and a
// 2000-cycle link timeout.
module tb_ctrl_rx_multi;

    localparam int NCH  = 2;
    localparam int CPB  = 16;
    localparam int TMO  = 2000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NCH-1:0]  rx  = '1;
    logic [NCH*7-1:0] btn;
    logic [NCH*7-1:0] press;
    logic [NCH-1:0]  valid;
    logic [NCH-1:0]  frm_err;
    logic [NCH-1:0]  link;

    ctrl_rx_multi #(
        .NUM_CH       (NCH),
        .CLKS_PER_BIT (CPB),
        .TIMEOUT_CYC  (TMO)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_rx      (rx),
        .o_btn     (btn),
        .o_press   (press),
        .o_valid   (valid),
        .o_frm_err (frm_err),
        .o_link    (link)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Pulse monitor, sampled on the falling edge.
    int         cyc = 0;
    int         valid_n [NCH];
    int         err_n   [NCH];
    int         press_n [NCH];
    logic [6:0] last_press [NCH];
    int         valid_cyc [NCH];
    int         fall_cyc  [NCH];
    logic [6:0] btn_at_fall [NCH];
    logic [6:0] btn_before_fall [NCH];
    logic       prev_link [NCH];
    logic [6:0] prev_btn  [NCH];

    initial begin
        for (int c = 0; c < NCH; c++) begin
            valid_n[c] = 0; err_n[c] = 0; press_n[c] = 0;
            last_press[c] = '0; valid_cyc[c] = -1; fall_cyc[c] = -1;
            btn_at_fall[c] = '0; btn_before_fall[c] = '0;
            prev_link[c] = 1'b0; prev_btn[c] = '0;
        end
    end

    always @(negedge clk) begin
        cyc++;
        for (int c = 0; c < NCH; c++) begin
            if (valid[c]) begin
                valid_n[c]++;
                valid_cyc[c] = cyc;
            end
            if (frm_err[c]) err_n[c]++;
            if (press[7*c +: 7] != 7'd0) begin
                press_n[c]++;
                last_press[c] = press[7*c +: 7];
            end
            if (prev_link[c] && !link[c]) begin
                fall_cyc[c]        = cyc;
                btn_at_fall[c]     = btn[7*c +: 7];
                btn_before_fall[c] = prev_btn[c];
            end
            prev_link[c] = link[c];
            prev_btn[c]  = btn[7*c +: 7];
        end
    end

    int sv [NCH];
    int se [NCH];
    int sp [NCH];

    task automatic snap();
        for (int c = 0; c < NCH; c++) begin
            sv[c] = valid_n[c]; se[c] = err_n[c]; sp[c] = press_n[c];
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends a frame on each enabled channel; extra_low keeps the stop slot
    // level for that many more cycles before the lines return high.
    task automatic send(input logic [1:0] en, input logic [7:0] b0, input logic [7:0] b1,
                        input logic st0, input logic st1, input int extra_low);
        logic [9:0] f0;
        logic [9:0] f1;
        f0 = {st0, b0, 1'b0};
        f1 = {st1, b1, 1'b0};
        for (int s = 0; s < 10; s++) begin
            rx[0] = en[0] ? f0[s] : 1'b1;
            rx[1] = en[1] ? f1[s] : 1'b1;
            repeat (CPB) @(posedge clk);
            #1;
        end
        if (extra_low > 0) idle(extra_low);
        rx = '1;
        idle(8);
    endtask

    initial begin
        // Reset state
        idle(5);
        chk("rst_btn", 32'(btn), 32'h0);
        chk("rst_press", 32'(press), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_err", 32'(frm_err), 32'h0);
        chk("rst_link", 32'(link), 32'h0);
        rst = 1'b0;
        idle(5);

        // Single frame on ch0
        snap();
        send(2'b01, 8'h05, 8'h00, 1'b1, 1'b1, 0);
        chk("f05_btn0", 32'(btn[6:0]), 32'h05);
        chk("f05_press", 32'(last_press[0]), 32'h05);
        chk("f05_press_n", 32'(press_n[0] - sp[0]), 32'd1);
        chk("f05_valid0", 32'(valid_n[0] - sv[0]), 32'd1);
        chk("f05_link0", 32'(link[0]), 32'd1);
        chk("f05_btn1", 32'(btn[13:7]), 32'h0);
        chk("f05_valid1", 32'(valid_n[1] - sv[1]), 32'd0);
        chk("f05_link1", 32'(link[1]), 32'd0);

        // Second frame: only newly pressed bits pulse
        snap();
        send(2'b01, 8'h07, 8'h00, 1'b1, 1'b1, 0);
        chk("f07_btn0", 32'(btn[6:0]), 32'h07);
        chk("f07_press", 32'(last_press[0]), 32'h02);
        chk("f07_valid0", 32'(valid_n[0] - sv[0]), 32'd1);

        // Good frame on ch1
        snap();
        send(2'b10, 8'h00, 8'h22, 1'b1, 1'b1, 0);
        chk("f22_btn1", 32'(btn[13:7]), 32'h22);
        chk("f22_valid1", 32'(valid_n[1] - sv[1]), 32'd1);
        chk("f22_btn0", 32'(btn[6:0]), 32'h07);

        // Bad stop bit with line held low 40 more cycles
        snap();
        send(2'b10, 8'h00, 8'h41, 1'b1, 1'b0, 40);
        chk("stop0_err1", 32'(err_n[1] - se[1]), 32'd1);
        chk("stop0_valid1", 32'(valid_n[1] - sv[1]), 32'd0);
        chk("stop0_btn1", 32'(btn[13:7]), 32'h22);
        chk("stop0_err0", 32'(err_n[0] - se[0]), 32'd0);

        // Bit 7 set is rejected
        snap();
        send(2'b10, 8'h00, 8'h81, 1'b1, 1'b1, 0);
        chk("b7_err1", 32'(err_n[1] - se[1]), 32'd1);
        chk("b7_valid1", 32'(valid_n[1] - sv[1]), 32'd0);
        chk("b7_btn1", 32'(btn[13:7]), 32'h22);

        // Short low glitch on ch0, then a good frame
        snap();
        rx[0] = 1'b0;
        idle(4);
        rx[0] = 1'b1;
        idle(40);
        chk("gl_valid0", 32'(valid_n[0] - sv[0]), 32'd0);
        chk("gl_err0", 32'(err_n[0] - se[0]), 32'd0);
        chk("gl_press0", 32'(press_n[0] - sp[0]), 32'd0);
        chk("gl_btn0", 32'(btn[6:0]), 32'h07);
        snap();
        send(2'b01, 8'h10, 8'h00, 1'b1, 1'b1, 0);
        chk("f10_btn0", 32'(btn[6:0]), 32'h10);
        chk("f10_press", 32'(last_press[0]), 32'h10);
        chk("f10_valid0", 32'(valid_n[0] - sv[0]), 32'd1);

        // 0x7F twice: second repeat gives valid but no press
        snap();
        send(2'b01, 8'h7F, 8'h00, 1'b1, 1'b1, 0);
        chk("f7f_press", 32'(last_press[0]), 32'h6F);
        chk("f7f_btn0", 32'(btn[6:0]), 32'h7F);
        snap();
        send(2'b01, 8'h7F, 8'h00, 1'b1, 1'b1, 0);
        chk("rep_valid0", 32'(valid_n[0] - sv[0]), 32'd1);
        chk("rep_press_n", 32'(press_n[0] - sp[0]), 32'd0);
        chk("rep_btn0", 32'(btn[6:0]), 32'h7F);

        // Link timeout, measured from the last accepted frame
        snap();
        idle(TMO + 100);
        chk("to_delay", 32'(fall_cyc[0] - valid_cyc[0]), 32'(TMO));
        chk("to_btn_at_fall", 32'(btn_at_fall[0]), 32'h0);
        chk("to_btn_before", 32'(btn_before_fall[0]), 32'h7F);
        chk("to_link0", 32'(link[0]), 32'd0);
        chk("to_btn0", 32'(btn[6:0]), 32'h0);
        chk("to_press_n", 32'(press_n[0] - sp[0]), 32'd0);

        // Simultaneous frames give both channels a non-zero state
        snap();
        send(2'b11, 8'h01, 8'h02, 1'b1, 1'b1, 0);
        chk("dual_btn", 32'(btn), 32'((7'h02 << 7) | 7'h01));
        chk("dual_link", 32'(link), 32'b11);

        // Reset pulsed mid-frame drops both frames
        snap();
        fork
            send(2'b11, 8'hF3, 8'hE5, 1'b1, 1'b1, 0);
            begin
                repeat (104) @(posedge clk);
                #1 rst = 1'b1;
                repeat (3) @(posedge clk);
                #1 rst = 1'b0;
            end
        join
        idle(10);
        chk("mrst_btn", 32'(btn), 32'h0);
        chk("mrst_link", 32'(link), 32'h0);
        chk("mrst_valid0", 32'(valid_n[0] - sv[0]), 32'd0);
        chk("mrst_valid1", 32'(valid_n[1] - sv[1]), 32'd0);
        chk("mrst_err0", 32'(err_n[0] - se[0]), 32'd0);
        chk("mrst_err1", 32'(err_n[1] - se[1]), 32'd0);

        // Frames after reset are received normally
        snap();
        send(2'b11, 8'h33, 8'h4C, 1'b1, 1'b1, 0);
        chk("post_btn", 32'(btn), 32'((7'h4C << 7) | 7'h33));
        chk("post_press0", 32'(last_press[0]), 32'h33);
        chk("post_press1", 32'(last_press[1]), 32'h4C);
        chk("post_valid0", 32'(valid_n[0] - sv[0]), 32'd1);
        chk("post_valid1", 32'(valid_n[1] - sv[1]), 32'd1);
        chk("post_link", 32'(link), 32'b11);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_rx_multi.md
CTRL_RX_MULTI -- requirements
Module: ctrl_rx_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning the number of independent player UART channels (1..8).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 938, meaning i_clk cycles per UART bit (>=8).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 10_800_000, meaning the idle cycles without an accepted frame before link loss.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port i_rx, input, NUM_CH bits: asynchronous UART lines, idle high, 8N1, LSB first.
REQ-007 SHALL have port o_btn, output, NUM_CH*7 bits: held button state; channel c occupies [7c+6:7c], bit order right, left, jump, squat, attack, defend, select (bit 0..6).
REQ-008 SHALL have port o_press, output, NUM_CH*7 bits: one-cycle pulse per newly pressed button (0->1), same layout as o_btn.
REQ-009 SHALL have port o_valid, output, NUM_CH bits: one-cycle pulse per accepted frame.
REQ-010 SHALL have port o_frm_err, output, NUM_CH bits: one-cycle pulse per rejected frame.
REQ-011 SHALL have port o_link, output, NUM_CH bits: high while the channel has received an accepted frame within TIMEOUT_CYC.

Function
REQ-012 SHALL pass each i_rx bit through a 2-flop synchronizer (reset value 1) before use; all timing below is relative to the synchronized line.
REQ-013 SHALL run one receiver FSM per channel with states IDLE, START, DATA, STOP, WAIT_HI; channels are fully independent.
REQ-014 SHALL leave IDLE for START on the first cycle the synchronized line is 0.
REQ-015 SHALL, in START, sample after CLKS_PER_BIT/2 cycles (integer divide); if 1, treat as a glitch and return to IDLE with no pulse; if 0, enter DATA.
REQ-016 SHALL, in DATA, sample 8 bits each CLKS_PER_BIT cycles apart, shifting LSB first, then enter STOP.
REQ-017 SHALL, in STOP, sample one CLKS_PER_BIT later; 1 means the frame is candidate-good and returns to IDLE; 0 pulses o_frm_err and enters WAIT_HI.
REQ-018 SHALL hold WAIT_HI until the synchronized line is 1, then go to IDLE (a break condition produces exactly one o_frm_err).
REQ-019 SHALL reject a candidate-good byte with bit 7 = 1: o_frm_err pulses, o_btn unchanged.
REQ-020 SHALL, on an accepted byte (stop = 1, bit 7 = 0), in the cycle after the stop sample, load o_btn[c] with byte[6:0], pulse o_valid[c], and pulse o_press[c] = byte[6:0] AND NOT the previous o_btn[c].
REQ-021 SHALL size bit counters to 3 bits and baud counters to $clog2(CLKS_PER_BIT) bits; the baud counter restarts on every state change.
REQ-022 SHALL keep a per-channel timeout counter of $clog2(TIMEOUT_CYC+1) bits, cleared on o_valid and saturating at TIMEOUT_CYC.
REQ-023 SHALL, when the timeout counter reaches TIMEOUT_CYC, drive o_link[c] low and clear o_btn[c] to 0 in the same cycle, with no o_press pulse.
REQ-024 SHALL set o_link[c] high in the same cycle as o_valid[c].
REQ-025 SHALL let an accepted frame win over timeout when both occur in the same cycle (button load, link stays high, counter clears).
REQ-026 SHALL repeat identical frames with o_valid pulses each time and no o_press pulse.

Reset
REQ-027 SHALL, while i_rst = 1 at a clock edge, force every FSM to IDLE, synchronizers to 1, all counters to 0, o_btn/o_press/o_valid/o_frm_err/o_link to 0.
REQ-028 SHALL discard any frame in progress when reset is asserted mid-frame; the first frame after release is received normally if its start edge follows release.

Verification (NUM_CH=2, CLKS_PER_BIT=16, TIMEOUT_CYC=2000)
REQ-029 SHALL cover: ch0 sends 0x05 -> o_btn[6:0]=0x05, o_press[6:0]=0x05 one cycle, o_valid[0] one pulse, o_link[0]=1; ch1 remains 0.
REQ-030 SHALL cover: ch0 sends 0x05 then 0x07 -> second frame gives o_press[6:0]=0x02, o_btn[6:0]=0x07.
REQ-031 SHALL cover: ch1 sends 0x41 with stop bit 0, line returning high 40 cycles later -> exactly one o_frm_err[1], o_btn[13:7] unchanged; ch1 sends 0x81 -> one o_frm_err[1], no o_valid.
REQ-032 SHALL cover: 4-cycle low glitch on ch0 -> no pulses, FSM back in IDLE; the following 0x10 frame is accepted.
REQ-033 SHALL cover: after 0x7F on ch0, no traffic for 2000 cycles -> o_link[0]=0 and o_btn[6:0]=0 at exactly 2000 cycles after o_valid, no o_press.
REQ-034 SHALL cover: both channels send different bytes simultaneously with i_rst pulsed mid-frame on ch0 -> ch0 frame dropped, all outputs 0; ch1 frame also dropped; subsequent frames on both accepted.
